// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts a byte stream (16-bit word count, then big-endian words),
// writes instruction memory and releases the core. Optional trailing XOR check byte: LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH = 72,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          core_reset,
  output logic          load_done,
  output logic          load_err
);

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    DATA,
    FLUSH,
`ifdef LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_LOAD = CHK;
`else
  localparam state_t AFTER_LOAD = DONE;
`endif

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t          state_q, state_d;
  logic [15:0]     count_q, count_d;
  logic [15:0]     widx_q, widx_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [23:0]     word_q, word_d;
  logic            imem_we_q, imem_we_d;
  logic [AW-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]     imem_wdata_q, imem_wdata_d;
  logic            accept;
  logic [15:0]     new_count;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  // Handshake and status outputs are pure decodes of the state register.
  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      CNT_HI, CNT_LO, DATA: rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      CHK:                  rx_ready = 1'b1;
`endif
      default:              rx_ready = 1'b0;
    endcase
  end

  assign accept     = rx_valid & rx_ready;
  assign new_count  = {count_q[15:8], rx_data};
  assign core_reset = (state_q != DONE);
  assign load_done  = (state_q == DONE);
  assign load_err   = (state_q == ERR);
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    widx_d       = widx_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    case (state_q)
      CNT_HI: begin
        if (accept) begin
          count_d[15:8] = rx_data;
          state_d       = CNT_LO;
        end
      end

      CNT_LO: begin
        if (accept) begin
          count_d[7:0] = rx_data;
          if ({1'b0, new_count} > DEPTH_W) begin
            state_d = ERR;
          end else if (new_count == 16'd0) begin
            state_d = AFTER_LOAD;
          end else begin
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (accept) begin
          word_d     = {word_q[15:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Fourth byte completes the word; the write strobe lands in the following cycle.
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = widx_q[AW-1:0];
            imem_wdata_d = {word_q, rx_data};
            widx_d       = widx_q + 16'd1;
            if (widx_q == count_q - 16'd1) begin
              state_d = FLUSH;
            end
          end
        end
      end

      FLUSH: state_d = AFTER_LOAD;

`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          state_d = (rx_data == csum_q) ? DONE : ERR;
        end
      end
`endif

      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase

`ifdef LOADER_CHECKSUM_EN
    if (accept && (state_q == CNT_HI || state_q == CNT_LO || state_q == DATA)) begin
      csum_d = csum_q ^ rx_data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CNT_HI;
      count_q      <= '0;
      widx_q       <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      widx_q       <= widx_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed vector table, hand sequences for
// timing/reset corners, and randomized streams checked against a stream-level model.
module tb_imem_loader;

  localparam int DEPTH = 72;
  localparam int AW    = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_reset;
  logic          load_done;
  logic          load_err;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]    stream[$];
  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  int            exp_addr[$];
  logic [31:0]   exp_data[$];
  bit            exp_done;

  typedef struct {
    string        name;
    logic [127:0] bytes;
    int           len;
    bit           exp_done;
    int           exp_nwr;
    logic [31:0]  exp_w0;
  } vec_t;

  vec_t vecs[$];

  always @(posedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reset    = 1'b1;
    step();
    step();
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic send_bytes(input int first, input int last, input int gap_pct);
    for (int i = first; i < last; i++) begin
      int n;
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        step();
      end
      rx_valid = 1'b1;
      rx_data  = stream[i];
      n = 0;
      while (!rx_ready && n < 20) begin
        step();
        n++;
      end
      if (n >= 20) begin
        total++;
        bad++;
        $display("FAIL ready_timeout: byte %0d never accepted, rx_ready=%b required=1", i, rx_ready);
        rx_valid = 1'b0;
        return;
      end
      step();
    end
    rx_valid = 1'b0;
  endtask

  // Reference: interpret the stream as count + big-endian words (+ XOR check byte).
  task automatic model();
    int cnt;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    cnt = {stream[0], stream[1]};
    if (cnt > DEPTH) begin
      exp_done = 1'b0;
      return;
    end
    for (int w = 0; w < cnt; w++) begin
      exp_addr.push_back(w);
      exp_data.push_back({stream[2+4*w], stream[3+4*w], stream[4+4*w], stream[5+4*w]});
    end
    exp_done = 1'b1;
`ifdef LOADER_CHECKSUM_EN
    x = 8'h00;
    for (int i = 0; i < 2 + 4 * cnt; i++) x = x ^ stream[i];
    exp_done = (stream[2 + 4 * cnt] == x);
`else
    x = 8'h00;
`endif
  endtask

  task automatic run_and_check(input string tag, input int gap_pct);
    int n;
    model();
    do_reset();
    send_bytes(0, stream.size(), gap_pct);
    n = 0;
    while (!(load_done || load_err) && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_done"}, 32'(load_done), 32'(exp_done));
    chk({tag, "_err"}, 32'(load_err), 32'(!exp_done));
    chk({tag, "_core_reset"}, 32'(core_reset), 32'(!exp_done));
    chk({tag, "_nwr"}, wr_addr.size(), exp_addr.size());
    for (int i = 0; i < wr_addr.size() && i < exp_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), 32'(exp_addr[i]));
      chk($sformatf("%s_data%0d", tag, i), wr_data[i], exp_data[i]);
    end
    if (exp_addr.size() > 0) begin
      chk({tag, "_addr_hold"}, 32'(imem_addr), 32'(exp_addr[exp_addr.size()-1]));
      chk({tag, "_data_hold"}, imem_wdata, exp_data[exp_data.size()-1]);
    end
  endtask

  task automatic add_vec(input string name, input logic [127:0] b, input int len,
                         input bit done, input int nwr, input logic [31:0] w0);
    vec_t v;
    v.name = name; v.bytes = b; v.len = len;
    v.exp_done = done; v.exp_nwr = nwr; v.exp_w0 = w0;
    vecs.push_back(v);
  endtask

  task automatic build_random(input int cnt, input bit corrupt);
    logic [7:0] x;
    stream.delete();
    stream.push_back(cnt[15:8]);
    stream.push_back(cnt[7:0]);
    if (cnt <= DEPTH) begin
      for (int i = 0; i < 4 * cnt; i++) stream.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
      x = 8'h00;
      foreach (stream[i]) x = x ^ stream[i];
      stream.push_back(corrupt ? (x ^ 8'h5A) : x);
`else
      x = {7'd0, corrupt};
`endif
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
`ifdef LOADER_CHECKSUM_EN
    add_vec("one_word",   128'h0001200800072E, 7, 1'b1, 1, 32'h20080007);
    add_vec("one_badck",  128'h0001200800072F, 7, 1'b0, 1, 32'h20080007);
    add_vec("zero_cnt",   128'h000000, 3, 1'b1, 0, 32'h0);
    add_vec("two_word",   128'h000211223344556677888A, 11, 1'b1, 2, 32'h11223344);
`else
    add_vec("one_word",   128'h000120080007, 6, 1'b1, 1, 32'h20080007);
    add_vec("zero_cnt",   128'h0000, 2, 1'b1, 0, 32'h0);
    add_vec("two_word",   128'h00021122334455667788, 10, 1'b1, 2, 32'h11223344);
`endif
    add_vec("cnt73",      128'h0049, 2, 1'b0, 0, 32'h0);
    add_vec("cnt256",     128'h0100, 2, 1'b0, 0, 32'h0);

    // Reset state
    do_reset();
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);

    // Directed table
    foreach (vecs[k]) begin
      stream.delete();
      for (int i = 0; i < vecs[k].len; i++)
        stream.push_back(vecs[k].bytes[8*(vecs[k].len-1-i) +: 8]);
      run_and_check(vecs[k].name, 0);
      chk({vecs[k].name, "_tbl_done"}, 32'(load_done), 32'(vecs[k].exp_done));
      chk({vecs[k].name, "_tbl_nwr"}, wr_addr.size(), vecs[k].exp_nwr);
      if (vecs[k].exp_nwr > 0 && wr_data.size() > 0)
        chk({vecs[k].name, "_tbl_w0"}, wr_data[0], vecs[k].exp_w0);
    end

    // Single-word timing: pulse in the cycle after the last byte, done one cycle later
    stream.delete();
    stream.push_back(8'h00); stream.push_back(8'h01); stream.push_back(8'h20);
    stream.push_back(8'h08); stream.push_back(8'h00); stream.push_back(8'h07);
    stream.push_back(8'h2E);
    do_reset();
    send_bytes(0, 6, 0);
    chk("seq_pulse_we", 32'(imem_we), 32'd1);
    chk("seq_pulse_addr", 32'(imem_addr), 32'd0);
    chk("seq_pulse_wdata", imem_wdata, 32'h20080007);
    chk("seq_pulse_core_reset", 32'(core_reset), 32'd1);
    chk("seq_pulse_done", 32'(load_done), 32'd0);
`ifdef LOADER_CHECKSUM_EN
    send_bytes(6, 7, 0);
`else
    step();
`endif
    chk("seq_done", 32'(load_done), 32'd1);
    chk("seq_core_released", 32'(core_reset), 32'd0);
    chk("seq_we_low", 32'(imem_we), 32'd0);

    // DONE ignores further traffic; reset re-asserts core_reset
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    step(); step(); step();
    rx_valid = 1'b0;
    chk("done_sticky", 32'(load_done), 32'd1);
    chk("done_no_extra_wr", wr_addr.size(), 1);
    reset = 1'b1;
    step();
    chk("done_rst_core_reset", 32'(core_reset), 32'd1);
    chk("done_rst_load_done", 32'(load_done), 32'd0);
    chk("done_rst_addr", 32'(imem_addr), 32'd0);
    chk("done_rst_wdata", imem_wdata, 32'd0);
    reset = 1'b0;

    // Reset after two bytes of word 3: no write of word 3, then a clean reload
    build_random(5, 1'b0);
    do_reset();
    send_bytes(0, 16, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_nwr", wr_addr.size(), 3);
    chk("midrst_rx_ready", 32'(rx_ready), 32'd1);
    chk("midrst_core_reset", 32'(core_reset), 32'd1);
    run_and_check("midrst_reload", 20);

    // Full-depth load with idle gaps
    build_random(DEPTH, 1'b0);
    run_and_check("full_depth", 30);

    // Randomized streams
    for (int it = 0; it < 8; it++) begin
      int cnt;
      cnt = (it == 0) ? DEPTH + 1 : int'($urandom_range(1, 20));
      build_random(cnt, (it % 3) == 2);
      run_and_check($sformatf("rand%0d", it), 30);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
